param_register_file: RTL and testbench



---
 rtl/param_register_file.sv | 88 ++++++++
 tb/tb_param_register_file.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_register_file.sv
// param_register_file: NREGS x WIDTH registers, each with its own function
// unit, two combinational read ports with optional write bypass and a wrap flag.
module param_register_file #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int SELW = $clog2(NREGS)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [NREGS-1:0] RegSel,
  input  logic [2:0]       FunSel,
  input  logic [SELW-1:0]  OutASel,
  input  logic [SELW-1:0]  OutBSel,
  input  logic             BypassEn,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic             Wrap
);

  localparam int H = WIDTH / 2;

  typedef logic [WIDTH-1:0] word_t;

  localparam word_t ONE = word_t'(1);

  logic [NREGS-1:0][WIDTH-1:0] regs_q;
  logic [NREGS-1:0][WIDTH-1:0] regs_d;
  logic                        wrap_q;
  logic                        wrap_d;

  function automatic word_t fu_next(
    input word_t      q,
    input logic [2:0] fs,
    input word_t      d
  );
    word_t r;
    r = q;
    unique case (fs)
      3'b000: r = q - ONE;
      3'b001: r = q + ONE;
      3'b010: r = d;
      3'b011: r = '0;
      3'b100: r = {{(WIDTH-H){1'b0}}, d[H-1:0]};
      3'b101: r = {q[WIDTH-1:H], d[H-1:0]};
      3'b110: r = {d[H-1:0], q[H-1:0]};
      3'b111: r = {{(WIDTH-H){d[H-1]}}, d[H-1:0]};
    endcase
    return r;
  endfunction

  function automatic logic wrap_hit(
    input word_t      q,
    input logic [2:0] fs
  );
    return ((fs == 3'b001) && (q == '1)) ||
           ((fs == 3'b000) && (q == '0));
  endfunction

  // regs_d doubles as the bypass source, so reset forces it to zero.
  always_comb begin
    regs_d = regs_q;
    wrap_d = 1'b0;
    for (int k = 0; k < NREGS; k++) begin
      if (Reset) begin
        regs_d[k] = '0;
      end else if (!RegSel[k]) begin
        regs_d[k] = fu_next(regs_q[k], FunSel, I);
        wrap_d    = wrap_d | wrap_hit(regs_q[k], FunSel);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      regs_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      wrap_q <= wrap_d;
    end
  end

  assign OutA = BypassEn ? regs_d[OutASel] : regs_q[OutASel];
  assign OutB = BypassEn ? regs_d[OutBSel] : regs_q[OutBSel];
  assign Wrap = wrap_q;

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file at three parameter points sharing one
// stimulus stream; expectations come from a behavioural model and constants.
module tb_param_register_file;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] I;
  logic [15:0] RegSel;
  logic [2:0]  FunSel;
  logic [3:0]  ASel;
  logic [3:0]  BSel;
  logic        BypassEn;

  logic [15:0] oa0, ob0;
  logic [7:0]  oa1, ob1;
  logic [31:0] oa2, ob2;
  logic        w0, w1, w2;

  always #5 Clock = ~Clock;

  param_register_file #(.WIDTH(16), .NREGS(8)) u0 (
    .Clock(Clock), .Reset(Reset), .I(I[15:0]),
    .RegSel(RegSel[7:0]), .FunSel(FunSel),
    .OutASel(ASel[2:0]), .OutBSel(BSel[2:0]),
    .BypassEn(BypassEn), .OutA(oa0), .OutB(ob0), .Wrap(w0)
  );

  param_register_file #(.WIDTH(8), .NREGS(4)) u1 (
    .Clock(Clock), .Reset(Reset), .I(I[7:0]),
    .RegSel(RegSel[3:0]), .FunSel(FunSel),
    .OutASel(ASel[1:0]), .OutBSel(BSel[1:0]),
    .BypassEn(BypassEn), .OutA(oa1), .OutB(ob1), .Wrap(w1)
  );

  param_register_file #(.WIDTH(32), .NREGS(16)) u2 (
    .Clock(Clock), .Reset(Reset), .I(I),
    .RegSel(RegSel), .FunSel(FunSel),
    .OutASel(ASel), .OutBSel(BSel),
    .BypassEn(BypassEn), .OutA(oa2), .OutB(ob2), .Wrap(w2)
  );

  int W[3] = '{16, 8, 32};
  int N[3] = '{8, 4, 16};

  logic [31:0] m  [3][16];
  logic [31:0] mn [3][16];
  logic        mw [3];
  logic        mwn[3];

  int errs   = 0;
  int checks = 0;

  typedef struct {
    string       nm;
    int          inst;
    logic [31:0] exp;
  } sb_t;

  sb_t sbq[$];

  typedef struct {
    string       nm;
    logic [2:0]  fs;
    logic [31:0] din;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [31:0] msk(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  function automatic logic [31:0] fu(input int w, input logic [31:0] q,
                                     input logic [2:0] fs,
                                     input logic [31:0] d);
    logic [31:0] mk, lm;
    int          h;
    h  = w / 2;
    mk = msk(w);
    lm = msk(h);
    case (fs)
      3'd0:    return (q - 32'h1) & mk;
      3'd1:    return (q + 32'h1) & mk;
      3'd2:    return d & mk;
      3'd3:    return 32'h0;
      3'd4:    return d & lm;
      3'd5:    return (q & mk & ~lm) | (d & lm);
      3'd6:    return ((d & lm) << h) | (q & lm);
      default: return (d[h-1] ? (mk & ~lm) : 32'h0) | (d & lm);
    endcase
  endfunction

  function automatic logic [31:0] outa(input int i);
    case (i)
      0:       return {16'h0, oa0};
      1:       return {24'h0, oa1};
      default: return oa2;
    endcase
  endfunction

  function automatic logic [31:0] outb(input int i);
    case (i)
      0:       return {16'h0, ob0};
      1:       return {24'h0, ob1};
      default: return ob2;
    endcase
  endfunction

  function automatic logic wrapo(input int i);
    case (i)
      0:       return w0;
      1:       return w1;
      default: return w2;
    endcase
  endfunction

  task automatic sb_push(input string nm, input int inst,
                         input logic [31:0] e);
    sb_t s;
    s.nm   = nm;
    s.inst = inst;
    s.exp  = e;
    sbq.push_back(s);
  endtask

  task automatic sb_cmp(input logic [31:0] act);
    sb_t s;
    checks++;
    if (sbq.size() == 0) begin
      errs++;
      $display("FAIL scoreboard_empty: got %h with no expectation", act);
      return;
    end
    s = sbq.pop_front();
    if (act !== s.exp) begin
      errs++;
      $display("FAIL %s inst%0d: got %h expected %h",
               s.nm, s.inst, act, s.exp);
    end
  endtask

  task automatic drive(input logic [15:0] rs, input logic [2:0] fs,
                       input logic [31:0] d);
    RegSel = rs;
    FunSel = fs;
    I      = d;
    for (int i = 0; i < 3; i++) begin
      mwn[i] = 1'b0;
      for (int k = 0; k < 16; k++) begin
        mn[i][k] = m[i][k];
        if (k < N[i] && !rs[k]) begin
          mn[i][k] = fu(W[i], m[i][k], fs, d);
          if ((fs == 3'd1 && m[i][k] == msk(W[i])) ||
              (fs == 3'd0 && m[i][k] == 32'h0))
            mwn[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic commit();
    @(posedge Clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      mw[i] = mwn[i];
      for (int k = 0; k < 16; k++) m[i][k] = mn[i][k];
    end
    RegSel = '1;
  endtask

  task automatic op(input logic [15:0] rs, input logic [2:0] fs,
                    input logic [31:0] d);
    @(negedge Clock);
    drive(rs, fs, d);
    commit();
  endtask

  task automatic chk_wrap(input string nm);
    for (int i = 0; i < 3; i++) sb_push(nm, i, {31'h0, mw[i]});
    for (int i = 0; i < 3; i++) sb_cmp({31'h0, wrapo(i)});
  endtask

  task automatic check_const(input int i, input int idx, input string nm,
                             input logic [31:0] e);
    @(negedge Clock);
    ASel     = 4'(idx);
    BSel     = 4'(idx);
    BypassEn = 1'b0;
    sb_push(nm, i, e);
    sb_push(nm, i, e);
    #1;
    sb_cmp(outa(i));
    sb_cmp(outb(i));
  endtask

  task automatic check_reg(input int i, input int idx, input string nm);
    check_const(i, idx, nm, m[i][idx]);
  endtask

  task automatic check_all(input string nm);
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < N[i]; k++) check_reg(i, k, nm);
  endtask

  task automatic do_reset(input logic [15:0] rs, input logic [2:0] fs,
                          input logic [31:0] d, input bit byp_chk);
    @(negedge Clock);
    Reset  = 1'b1;
    RegSel = rs;
    FunSel = fs;
    I      = d;
    if (byp_chk) begin
      BypassEn = 1'b1;
      ASel     = 4'd3;
      BSel     = 4'd1;
      for (int i = 0; i < 3; i++) begin
        sb_push("rst_bypass_a", i, 32'h0);
        sb_push("rst_bypass_b", i, 32'h0);
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        sb_cmp(outa(i));
        sb_cmp(outb(i));
      end
      BypassEn = 1'b0;
    end
    @(posedge Clock);
    #1;
    Reset  = 1'b0;
    RegSel = '1;
    for (int i = 0; i < 3; i++) begin
      mw[i] = 1'b0;
      for (int k = 0; k < 16; k++) m[i][k] = 32'h0;
    end
  endtask

  initial begin
    tbl[0] = '{"hw_100",    3'd4, 32'h0000_AB80, 16'h0080};
    tbl[1] = '{"hw_101",    3'd5, 32'h0000_AB80, 16'h1280};
    tbl[2] = '{"hw_110",    3'd6, 32'h0000_AB80, 16'h8034};
    tbl[3] = '{"sext_neg",  3'd7, 32'h0000_AB80, 16'hFF80};
    tbl[4] = '{"sext_pos",  3'd7, 32'h0000_007F, 16'h007F};
    tbl[5] = '{"inc",       3'd1, 32'h0000_0000, 16'h1235};
    tbl[6] = '{"dec",       3'd0, 32'h0000_0000, 16'h1233};
    tbl[7] = '{"clear",     3'd3, 32'h0000_5555, 16'h0000};
    tbl[8] = '{"load",      3'd2, 32'h1357_BEEF, 16'hBEEF};

    Reset    = 1'b1;
    RegSel   = '1;
    FunSel   = 3'd0;
    I        = 32'h0;
    ASel     = 4'd0;
    BSel     = 4'd0;
    BypassEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mw[i] = 1'b0;
      for (int k = 0; k < 16; k++) m[i][k] = 32'h0;
    end
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;

    chk_wrap("reset_wrap");
    check_reg(0, 0, "reset_r0");
    check_reg(1, 3, "reset_r3");
    check_reg(2, 15, "reset_r15");

    op(16'h0000, 3'd2, 32'h0000_1234);
    check_reg(0, 4, "load_all");
    check_reg(2, 9, "load_all");
    do_reset('1, 3'd0, 32'h0, 1'b0);
    chk_wrap("reset1_wrap");
    check_all("reset1");

    op(16'h0000, 3'd2, 32'h0000_1234);
    do_reset(16'h0000, 3'd2, 32'h0000_1234, 1'b1);
    chk_wrap("reset2_wrap");
    check_all("reset2");

    for (int t = 0; t < 9; t++) begin
      op(16'hFFFE, 3'd2, 32'h0000_1234);
      op(16'hFFFE, tbl[t].fs, tbl[t].din);
      check_const(0, 0, tbl[t].nm, {16'h0, tbl[t].exp});
      check_reg(1, 0, tbl[t].nm);
      check_reg(2, 0, tbl[t].nm);
    end

    op(16'hFFFB, 3'd2, 32'hFFFF_FFFF);
    op(16'hFFFB, 3'd1, 32'h0);
    chk_wrap("inc_wrap_set");
    for (int i = 0; i < 3; i++) check_const(i, 2, "inc_wrap_r2", 32'h0);
    op('1, 3'd1, 32'h0);
    chk_wrap("wrap_cleared");

    op(16'hFFDF, 3'd3, 32'h0);
    op(16'hFFDF, 3'd0, 32'h0);
    chk_wrap("dec_wrap_r5");
    check_const(0, 5, "dec_r5", 32'h0000_FFFF);
    check_const(2, 5, "dec_r5", 32'hFFFF_FFFF);
    op(16'hFFFD, 3'd3, 32'h0);
    op(16'hFFFD, 3'd0, 32'h0);
    chk_wrap("dec_wrap_r1");
    check_const(1, 1, "dec_r1", 32'h0000_00FF);

    op(16'hFFF7, 3'd2, 32'h0000_0010);
    @(negedge Clock);
    ASel     = 4'd3;
    BSel     = 4'd3;
    BypassEn = 1'b1;
    drive(16'hFFF7, 3'd1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      sb_push("bypass_on_a", i, 32'h11);
      sb_push("bypass_on_b", i, 32'h11);
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      sb_cmp(outa(i));
      sb_cmp(outb(i));
    end
    BypassEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sb_push("bypass_off_a", i, 32'h10);
      sb_push("bypass_off_b", i, 32'h10);
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      sb_cmp(outa(i));
      sb_cmp(outb(i));
    end
    commit();
    for (int i = 0; i < 3; i++) check_const(i, 3, "bypass_after", 32'h11);

    op(16'hFFFD, 3'd2, 32'h5);
    op(16'hFFBF, 3'd2, 32'h1);
    op(16'hFFBD, 3'd0, 32'h0);
    chk_wrap("multi_wrap");
    check_const(0, 1, "multi_r1", 32'h4);
    check_const(0, 6, "multi_r6", 32'h0);
    check_all("multi_all");

    op(16'hFFFE, 3'd7, 32'h0000_0080);
    check_const(1, 0, "w8_sext_80", 32'h00);
    check_const(0, 0, "w16_sext_80", 32'hFF80);
    op(16'hFFFE, 3'd7, 32'h0000_0008);
    check_const(1, 0, "w8_sext_08", 32'hF8);
    check_const(2, 0, "w32_sext_08", 32'h8);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
